comparator: RTL and testbench
=============================

# comparator

Registered 8-bit magnitude comparator for the ALU. It compares operands A and B as unsigned or two's-complement signed values, selected by `sign`. It drives exactly one of three one-hot flags (equal, less-than, greater-than), which feed the ALU flag logic and branch-condition evaluation. Outputs are registered, so results appear one clock after the operands are sampled.

## Interface
- WIDTH, 8, operand width in bits; all requirements below hold for any WIDTH ≥ 2, and the design is verified at 8.
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  synchronous, active-low reset, sampled on rising edge of clk.
- A  input  WIDTH  left operand.
- B  input  WIDTH  right operand.
- sign  input  1  0 = unsigned compare, 1 = two's-complement signed compare.
- eq  output  1  registered; 1 when A == B.
- lt  output  1  registered; 1 when A < B under the selected interpretation.
- gt  output  1  registered; 1 when A > B under the selected interpretation.

## Operation
- Each rising edge with rst_n = 1: sample A, B and sign, compute the relation, and load eq/lt/gt.
- Equality ignores sign: eq = (A == B) bit-for-bit.
- Unsigned (sign = 0): plain magnitude compare over all WIDTH bits.
  - Examples: 0x9C > 0x97; 0xC1 < 0xC2; 0x80 > 0x7F.
- Signed (sign = 1): MSB is the sign bit.
  - Sign bits differ: the operand with MSB = 1 is smaller (0x88 = -120 < 0x1E = 30; 0x80 = -128 < 0x7F = 127).
  - Sign bits equal: the result equals the unsigned compare of the full words (0xE1 = -31 < 0xE2 = -30).
- One-hot invariant: after reset, exactly one of eq/lt/gt is 1 on every cycle. Two of them are never 1 together.
- Compute the relation without a subtractor-overflow path. Use a single magnitude comparator, then invert its lt/gt when sign = 1 and the MSBs differ.
- No internal state other than the three output flops.

## Timing
- Latency: 1 cycle. Inputs present before edge N are reflected on eq/lt/gt immediately after edge N, and held until edge N+1.
- No combinational path from inputs to outputs.
- Reset: on a rising edge with rst_n = 0, eq = 0, lt = 0, gt = 0. This is the only state in which no flag is set.
  - While rst_n is low, outputs hold 0 regardless of A/B/sign.
- Reset release: the first edge with rst_n = 1 loads a valid result, so flags are valid one cycle after deassertion.
- Reset asserted mid-stream: the next edge clears all flags. No result from earlier inputs appears afterward.
- Changing `sign` between cycles with the same A/B is allowed. The result for the new mode appears after the next edge (e.g., 0x80 vs 0x7F gives gt, then lt).
- Inputs between edges are don't-care. Only values at the rising edge matter.

## Test plan
- Reset: rst_n = 0 for 2 cycles with A = B = 0x10 -> eq = lt = gt = 0. Release -> after next edge, eq = 1.
- Unsigned sweep, sign = 0:
  - A = 0x10, B = 0x10 -> eq.
  - A = 0x9C, B = 0x97 -> gt.
  - A = 0xC1, B = 0xC2 -> lt.
  - Each result appears exactly one cycle after being applied.
- Signed sweep, sign = 1:
  - 0xE2/0xE2 -> eq.
  - 0xE1/0xE2 -> lt.
  - 0x88/0x1E -> lt.
  - 0x1E/0x88 -> gt.
  - 0x7F/0x80 -> gt.
  - 0x80/0x7F -> lt.
- Mode flip: A = 0x80, B = 0x7F held, sign toggled 0 -> 1 -> 0 -> flags gt, lt, gt on successive cycles.
- Mid-stream reset: back-to-back vectors, then rst_n = 0 for 1 cycle -> flags 0 on that cycle, and the correct result for the current inputs on the following cycle.
- Randomized: 10k random A/B/sign vs a reference model, delayed 1 cycle -> exact match. Check the one-hot invariant every non-reset cycle.

Source files
------------

// File: rtl/comparator.sv
// rtl/comparator.sv - registered signed/unsigned magnitude comparator with one-hot eq/lt/gt flags
module comparator #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             sign,
  output logic             eq,
  output logic             lt,
  output logic             gt
);

  logic mag_lt;
  logic mag_gt;
  logic msb_diff;
  logic flip;
  logic nxt_eq;
  logic nxt_lt;
  logic nxt_gt;

  // One unsigned magnitude compare; in signed mode with differing sign bits
  // the operand with MSB set is the negative one, so lt/gt simply swap.
  // When the sign bits match, the unsigned order of the full words is already
  // the signed order, so no subtractor or overflow detection is needed.
  always_comb begin
    mag_lt   = 1'b0;
    mag_gt   = 1'b0;
    msb_diff = 1'b0;
    flip     = 1'b0;
    nxt_eq   = 1'b0;
    nxt_lt   = 1'b0;
    nxt_gt   = 1'b0;

    mag_lt   = (A < B);
    mag_gt   = (A > B);
    msb_diff = A[WIDTH-1] ^ B[WIDTH-1];
    flip     = sign & msb_diff;

    nxt_eq   = (A == B);
    nxt_lt   = flip ? mag_gt : mag_lt;
    nxt_gt   = flip ? mag_lt : mag_gt;
  end

  // Output flags are the only state; reset clears all three, which is the
  // only time no flag is asserted.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      eq <= 1'b0;
      lt <= 1'b0;
      gt <= 1'b0;
    end else begin
      eq <= nxt_eq;
      lt <= nxt_lt;
      gt <= nxt_gt;
    end
  end

endmodule

// File: tb/tb_comparator.sv
// tb/tb_comparator.sv - directed and randomized self-checking bench for comparator
module tb_comparator;

  localparam logic [2:0] F_EQ   = 3'b100;
  localparam logic [2:0] F_LT   = 3'b010;
  localparam logic [2:0] F_GT   = 3'b001;
  localparam logic [2:0] F_NONE = 3'b000;

  logic       clk;
  logic       rst_n;
  logic [7:0] A;
  logic [7:0] B;
  logic       sign;
  logic       eq;
  logic       lt;
  logic       gt;

  int errors;
  int checks;
  logic [2:0] held;

  comparator #(.WIDTH(8)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .A    (A),
    .B    (B),
    .sign (sign),
    .eq   (eq),
    .lt   (lt),
    .gt   (gt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [2:0] flags();
    return {eq, lt, gt};
  endfunction

  // Independent reference built on the language's own signed/unsigned compare
  function automatic logic [2:0] cmp_ref(input logic [7:0] a, input logic [7:0] b, input logic s);
    logic signed [7:0] sa;
    logic signed [7:0] sb;
    sa = a;
    sb = b;
    if (a == b) return F_EQ;
    if (s) return (sa < sb) ? F_LT : F_GT;
    return (a < b) ? F_LT : F_GT;
  endfunction

  task automatic check(input string tag, input logic [2:0] got, input logic [2:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got {eq,lt,gt}=%b expected=%b", tag, got, exp);
    end
  endtask

  // Drive a vector away from the edge, confirm the old result still holds,
  // then confirm the new result one edge later.
  task automatic apply(input logic [7:0] a, input logic [7:0] b, input logic s,
                       input logic [2:0] exp, input string tag);
    @(negedge clk);
    A    = a;
    B    = b;
    sign = s;
    #1;
    check({tag, "_hold"}, flags(), held);
    @(posedge clk);
    #1;
    check(tag, flags(), exp);
    check({tag, "_onehot"}, {2'b00, $onehot(flags())}, 3'b001);
    held = exp;
  endtask

  initial begin
    logic [7:0] ra;
    logic [7:0] rb;
    logic       rs;

    errors = 0;
    checks = 0;
    held   = F_NONE;
    rst_n  = 1'b0;
    A      = 8'h10;
    B      = 8'h10;
    sign   = 1'b0;

    // reset held for two edges with equal operands
    @(posedge clk); #1;
    check("reset_c1", flags(), F_NONE);
    @(posedge clk); #1;
    check("reset_c2", flags(), F_NONE);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("release_hold", flags(), F_NONE);
    @(posedge clk); #1;
    check("release_eq", flags(), F_EQ);
    held = F_EQ;

    // unsigned sweep
    apply(8'h10, 8'h10, 1'b0, F_EQ, "u_10_10");
    apply(8'h9C, 8'h97, 1'b0, F_GT, "u_9c_97");
    apply(8'hC1, 8'hC2, 1'b0, F_LT, "u_c1_c2");
    apply(8'h80, 8'h7F, 1'b0, F_GT, "u_80_7f");
    apply(8'h00, 8'hFF, 1'b0, F_LT, "u_00_ff");

    // signed sweep
    apply(8'hE2, 8'hE2, 1'b1, F_EQ, "s_e2_e2");
    apply(8'hE1, 8'hE2, 1'b1, F_LT, "s_e1_e2");
    apply(8'h88, 8'h1E, 1'b1, F_LT, "s_88_1e");
    apply(8'h1E, 8'h88, 1'b1, F_GT, "s_1e_88");
    apply(8'h7F, 8'h80, 1'b1, F_GT, "s_7f_80");
    apply(8'h80, 8'h7F, 1'b1, F_LT, "s_80_7f");
    apply(8'hFF, 8'h00, 1'b1, F_LT, "s_ff_00");

    // mode flip with operands held
    apply(8'h80, 8'h7F, 1'b0, F_GT, "flip_u0");
    apply(8'h80, 8'h7F, 1'b1, F_LT, "flip_s1");
    apply(8'h80, 8'h7F, 1'b0, F_GT, "flip_u2");

    // mid-stream reset: back-to-back vectors, then a one-cycle reset
    apply(8'h9C, 8'h97, 1'b0, F_GT, "mid_pre1");
    apply(8'hC1, 8'hC2, 1'b0, F_LT, "mid_pre2");
    @(negedge clk);
    rst_n = 1'b0;
    A     = 8'h88;
    B     = 8'h1E;
    sign  = 1'b1;
    @(posedge clk); #1;
    check("mid_reset", flags(), F_NONE);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("mid_release", flags(), F_LT);
    held = F_LT;

    // randomized against the reference model
    for (int i = 0; i < 10000; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = ($urandom_range(0, 7) == 0) ? ra : 8'($urandom_range(0, 255));
      rs = 1'($urandom_range(0, 1));
      apply(ra, rb, rs, cmp_ref(ra, rb, rs), "rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
